// File: rtl/nfu_1_stream.sv
// nfu_1_stream: streaming Tn x Tn fixed-point multiplier array.
// Each accepted beat carries Tn inputs, Tn*Tn synapses and a mode bit; the
// result element (r,j) = inputs[j] * synapses[r,j], shifted right by FRAC and
// either saturated (mode 0) or wrapped (mode 1) to N bits.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   i_valid/i_ready     input beat handshake
//   i_mode              0 = saturate, 1 = wrap (travels with the beat)
//   i_inputs            Tn x N-bit signed inputs
//   i_synapses          Tn*Tn x N-bit signed synapses, row-major
//   o_valid/o_ready     result beat handshake
//   o_results           Tn*Tn x N-bit results, same layout as i_synapses
//   o_beats             free-running count of delivered result beats
module nfu_1_stream #(
  parameter int N    = 16,
  parameter int Tn   = 16,
  parameter int LAT  = 5,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_mode,
  input  logic [N*Tn-1:0]      i_inputs,
  input  logic [N*Tn*Tn-1:0]   i_synapses,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N*Tn*Tn-1:0]   o_results,
  output logic [31:0]          o_beats
);

  localparam int RW = N * Tn * Tn;
  localparam logic signed [2*N-1:0] QMAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N-1:0] QMIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

  logic            en;
  logic [LAT-1:0]  vld;
  logic [N*Tn-1:0] s0_in;
  logic [RW-1:0]   s0_syn;
  logic            s0_mode;
  logic [RW-1:0]   prod;
  logic [RW-1:0]   res [1:LAT-1];

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en        = o_ready || !o_valid;
  // During reset the pipeline is being emptied, so advertise readiness; the
  // beat is still not captured because the valid shift is held in reset.
  assign i_ready   = en || !rst_n;
  assign o_valid   = vld[LAT-1];
  assign o_results = res[LAT-1];

  // Stage 0 registers the raw beat; stage 1 holds the computed products.
  for (genvar r = 0; r < Tn; r++) begin : g_row
    for (genvar j = 0; j < Tn; j++) begin : g_col
      logic signed [N-1:0]   a;
      logic signed [N-1:0]   s;
      logic signed [2*N-1:0] p;
      logic signed [2*N-1:0] q;
      logic        [N-1:0]   y;

      assign a = s0_in[j*N +: N];
      assign s = s0_syn[(r*Tn+j)*N +: N];
      assign p = (2*N)'(a) * (2*N)'(s);
      assign q = p >>> FRAC;

      always_comb begin
        y = q[N-1:0];
        if (!s0_mode) begin
          if (q > QMAX)      y = QMAX[N-1:0];
          else if (q < QMIN) y = QMIN[N-1:0];
        end
      end

      assign prod[(r*Tn+j)*N +: N] = y;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (en) begin
      vld <= {vld[LAT-2:0], i_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      s0_in   <= i_inputs;
      s0_syn  <= i_synapses;
      s0_mode <= i_mode;
      res[1]  <= prod;
      for (int unsigned k = 2; k < LAT; k++) begin
        res[k] <= res[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_beats <= '0;
    end else if (o_valid && o_ready) begin
      o_beats <= o_beats + 32'd1;
    end
  end

endmodule

// File: tb/tb_nfu_1_stream.sv
module tb_nfu_1_stream;

  localparam int N    = 16;
  localparam int Tn   = 4;
  localparam int LAT  = 5;
  localparam int FRAC = 8;
  localparam int RW   = N * Tn * Tn;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready;
  logic            i_mode = 1'b0;
  logic [N*Tn-1:0] i_inputs = '0;
  logic [RW-1:0]   i_synapses = '0;
  logic            o_valid;
  logic            o_ready = 1'b1;
  logic [RW-1:0]   o_results;
  logic [31:0]     o_beats;

  nfu_1_stream #(.N(N), .Tn(Tn), .LAT(LAT), .FRAC(FRAC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_mode     (i_mode),
    .i_inputs   (i_inputs),
    .i_synapses (i_synapses),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_results  (o_results),
    .o_beats    (o_beats)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] res;
    int            t;
  } beat_t;

  beat_t           q[$];
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  int              dcount = 0;
  int              acount = 0;
  logic [31:0]     exp_beats = '0;
  bit              lat_chk = 1'b0;
  bit              stalled = 1'b0;
  bit              prev_rst = 1'b0;
  bit              chk_full = 1'b0;
  logic [RW-1:0]   held_res = '0;
  logic [RW-1:0]   last_res = '0;
  logic [N*Tn-1:0] nxt_in = '0;
  logic [RW-1:0]   nxt_syn = '0;

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, floor shift, clamp or keep low bits.
  function automatic logic [RW-1:0] model(input logic [N*Tn-1:0] a, input logic [RW-1:0] s,
                                          input logic m);
    logic [RW-1:0] r;
    longint lo, hi, av, sv, p, qv;
    lo = -(longint'(1) << (N-1));
    hi = (longint'(1) << (N-1)) - 1;
    r = '0;
    for (int row = 0; row < Tn; row++) begin
      for (int j = 0; j < Tn; j++) begin
        av = longint'($signed(a[j*N +: N]));
        sv = longint'($signed(s[(row*Tn+j)*N +: N]));
        p  = av * sv;
        qv = p >>> FRAC;
        if (!m) begin
          if (qv > hi) qv = hi;
          if (qv < lo) qv = lo;
        end
        r[(row*Tn+j)*N +: N] = qv[N-1:0];
      end
    end
    return r;
  endfunction

  task automatic rand_data();
    for (int k = 0; k < Tn; k++) nxt_in[k*N +: N] = N'($urandom);
    for (int k = 0; k < Tn*Tn; k++) nxt_syn[k*N +: N] = N'($urandom);
  endtask

  task automatic step(input bit iv, input bit md, input bit ordy, input bit rstn, input bit frc);
    bit acc, dlv;
    beat_t b;
    @(negedge clk);
    chk("beats", o_beats, exp_beats);
    if (prev_rst) begin
      chk("rst_ovalid", o_valid, 0);
      chk("rst_iready", i_ready, 1);
    end
    if (chk_full) begin
      chk("full_iready", i_ready, 0);
      chk("full_occ", q.size(), LAT);
      chk_full = 1'b0;
    end
    if (stalled) begin
      chk("hold_valid", o_valid, 1);
      chk("hold_res", o_results, held_res);
    end
    if (frc) begin
      force dut.o_beats = 32'hFFFF_FFFF;
      #1;
      release dut.o_beats;
      exp_beats = 32'hFFFF_FFFF;
    end
    rst_n = rstn; i_valid = iv; i_mode = md; o_ready = ordy;
    i_inputs = nxt_in; i_synapses = nxt_syn;
    #1;
    acc = rstn && i_valid && i_ready;
    dlv = rstn && o_valid && o_ready;
    if (dlv) begin
      if (q.size() == 0) begin
        chk("spurious", 1, 0);
      end else begin
        b = q.pop_front();
        chk("res", o_results, b.res);
        if (lat_chk) chk("latency", cyc + 1 - b.t, LAT);
      end
      last_res = o_results;
      exp_beats++;
      dcount++;
    end
    if (acc) begin
      q.push_back('{res: model(i_inputs, i_synapses, i_mode), t: cyc + 1});
      acount++;
    end
    if (!rstn) begin
      q.delete();
      exp_beats = '0;
    end
    prev_rst = !rstn;
    stalled  = rstn && o_valid && !o_ready;
    held_res = o_results;
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() > 0 && k < 4*LAT + 40) begin
      step(0, 0, 1, 1, 0);
      k++;
    end
    step(0, 0, 1, 1, 0);
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int d0, a0, k;
    logic [RW-1:0] unity;

    // Reset, with a beat presented that must not be captured.
    rand_data();
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);

    // Unity scaling: 1.0 * 2.0 = 2.0 in every element, exact latency.
    for (int e = 0; e < Tn; e++) nxt_in[e*N +: N] = 16'h0100;
    for (int e = 0; e < Tn*Tn; e++) nxt_syn[e*N +: N] = 16'h0200;
    lat_chk = 1'b1;
    step(1, 0, 1, 1, 0);
    drain();
    for (int e = 0; e < Tn*Tn; e++) unity[e*N +: N] = 16'h0200;
    chk("unity", last_res, unity);

    // Saturation corners, then the wrap case.
    rand_data();
    nxt_in[0*N +: N] = 16'h7FFF; nxt_syn[0*N +: N] = 16'h7FFF;
    nxt_in[1*N +: N] = 16'h8000; nxt_syn[1*N +: N] = 16'h7FFF;
    nxt_in[2*N +: N] = 16'hFF00; nxt_syn[2*N +: N] = 16'h0100;
    nxt_in[3*N +: N] = 16'h7FFF; nxt_syn[3*N +: N] = 16'h7FFF;
    step(1, 0, 1, 1, 0);
    drain();
    chk("sat_pos", last_res[0*N +: N], 16'h7FFF);
    chk("sat_neg", last_res[1*N +: N], 16'h8000);
    chk("neg_exact", last_res[2*N +: N], 16'hFF00);
    step(1, 1, 1, 1, 0);
    drain();
    chk("wrap_elem", last_res[3*N +: N], 16'hFF00);
    lat_chk = 1'b0;

    // Back-to-back stream with alternating modes, no stalls.
    for (int i = 0; i < 8; i++) begin
      rand_data();
      step(1, i[0], 1, 1, 0);
    end
    drain();

    // Random stream: 20 beats, random mode, 50% o_ready.
    step(0, 0, 1, 0, 0);
    d0 = dcount; a0 = acount; k = 0;
    while (acount - a0 < 20 && k < 400) begin
      rand_data();
      step(($urandom % 4) != 0, $urandom % 2, $urandom % 2, 1, 0);
      k++;
    end
    k = 0;
    while (q.size() > 0 && k < 400) begin
      step(0, 0, $urandom % 2, 1, 0);
      k++;
    end
    drain();
    chk("stream_count", dcount - d0, 20);

    // Fill while blocked, then release: one beat per cycle.
    for (int i = 0; i < LAT + 3; i++) begin
      rand_data();
      step(1, $urandom % 2, 0, 1, 0);
    end
    chk_full = 1'b1;
    d0 = dcount;
    for (int i = 0; i < LAT; i++) step(0, 0, 1, 1, 0);
    chk("burst_count", dcount - d0, LAT);
    drain();

    // Reset with LAT beats in flight: nothing may emerge afterwards.
    for (int i = 0; i < LAT; i++) begin
      rand_data();
      step(1, 0, 1, 1, 0);
    end
    step(1, 0, 1, 0, 0);
    d0 = dcount;
    for (int i = 0; i < 2*LAT; i++) step(0, 0, 1, 1, 0);
    chk("rst_flush", dcount - d0, 0);

    // Counter wrap.
    rand_data();
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < LAT; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 1, 0);
    chk("wrap_beats", exp_beats, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nfu_1_stream.md
NFU_1_STREAM -- requirements
Module: nfu_1_stream

Interface
REQ-001 Parameter N, default 16, width in bits of every input, synapse and result element (signed two's complement).
REQ-002 Parameter Tn, default 16, number of input neurons; the synapse/result array is Tn x Tn.
REQ-003 Parameter LAT, default 5, total pipeline depth in cycles from accepted beat to result; legal range 2..8.
REQ-004 Parameter FRAC, default 8, fractional bits of the fixed-point format; legal range 0..N-1.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-007 i_valid  input  1  upstream beat present.
REQ-008 i_ready  output  1  block accepts a beat this cycle.
REQ-009 i_mode  input  1  0 = saturate, 1 = wrap; qualified by i_valid.
REQ-010 i_inputs  input  N*Tn  Tn input values; element j at bits [(j+1)*N-1 : j*N].
REQ-011 i_synapses  input  N*Tn*Tn  row-major Tn x Tn synapses; element (r,j) at index r*Tn+j.
REQ-012 o_valid  output  1  result beat present.
REQ-013 o_ready  input  1  downstream accepts result beat.
REQ-014 o_results  output  N*Tn*Tn  products; element (r,j) = i_inputs[j] x i_synapses[r,j], same index layout as i_synapses.
REQ-015 o_beats  output  32  count of result beats delivered (o_valid && o_ready).

Function
REQ-016 Beat accepted when i_valid && i_ready; result delivered when o_valid && o_ready.
REQ-017 Pipeline advance enable en = o_ready || !o_valid; i_ready SHALL equal en (combinational, no path from i_valid).
REQ-018 When en = 0, all stage data and valid bits SHALL hold unchanged (global stall); o_results and o_valid stable while o_valid && !o_ready.
REQ-019 When en = 1, each stage valid bit loads the previous stage's; stage 0 loads i_valid; data of invalid stages is don't-care.
REQ-020 Uninterrupted latency: a beat accepted at cycle t with o_ready held 1 SHALL appear on o_valid at cycle t+LAT.
REQ-021 Throughput: one beat per cycle with o_ready held 1; no bubbles inserted.
REQ-022 Beat order preserved; no beat dropped or duplicated under any o_ready pattern.
REQ-023 i_mode SHALL travel with its beat; mode changes between beats apply per beat.
REQ-024 Arithmetic: full signed 2N-bit product p = a x s; q = p arithmetically shifted right by FRAC (floor, no rounding).
REQ-025 Mode 0: q clamped to [-2^(N-1), 2^(N-1)-1]; mode 1: low N bits of q.
REQ-026 Saturation/truncation SHALL be applied independently per element.
REQ-027 o_beats increments by 1 per delivered beat, wraps 0xFFFFFFFF -> 0, no saturation.
REQ-028 Beat accepted in the same cycle another is delivered: both handled, occupancy unchanged.

Reset
REQ-029 rst_n = 0 at posedge clk SHALL clear all stage valid bits and o_beats to 0; o_valid = 0 the following cycle.
REQ-030 Reset mid-operation: all in-flight beats discarded, none delivered after reset.
REQ-031 o_results value after reset is don't-care while o_valid = 0; i_ready = 1 during and after reset (o_valid = 0).
REQ-032 A beat presented in the cycle rst_n = 0 SHALL NOT be accepted into the pipeline.

Verification
REQ-033 N=16, FRAC=8, mode 0, all inputs 0x0100, all synapses 0x0200, o_ready=1 -> every element 0x0200 exactly LAT cycles after acceptance.
REQ-034 Mode 0: 0x7FFF x 0x7FFF -> 0x7FFF; 0x8000 x 0x7FFF -> 0x8000; 0xFF00 x 0x0100 -> 0xFF00; mode 1: 0x7FFF x 0x7FFF -> 0xFF00.
REQ-035 Stream 20 beats with distinct tags, o_ready random 50% -> all 20 delivered in order, values stable during stall, o_beats = 20.
REQ-036 Fill pipeline with o_ready=0 -> i_ready falls once o_valid=1; raise o_ready -> back-to-back delivery, one beat per cycle, no loss.
REQ-037 Assert rst_n=0 for one cycle with LAT beats in flight -> o_valid=0 next cycle, o_beats=0, no stale beat ever delivered.
REQ-038 Force o_beats to 0xFFFFFFFF, deliver one beat -> o_beats = 0x00000000.
